// File: rtl/mt_pkg.sv
// Shared types and constants for the Mersenne-Twister request arbiter.
package mt_pkg;

    typedef enum logic [1:0] {
        ST_RESEED,
        ST_FILL,
        ST_ARB,
        ST_SETTLE
    } arb_state_e;

    localparam logic [31:0] MT_DEFAULT_SEED = 32'd5489;
    localparam int          MT_N            = 624;

    // Width of a requester index; never below one bit so NREQ=2 still works.
    function automatic int req_idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first requester at or after ptr
// (wrapping past NREQ-1 back to 0) wins.
module rr_arbiter
    import mt_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]                 req,
    input  logic [req_idx_width(NREQ)-1:0]  ptr,
    output logic [NREQ-1:0]                 winner,
    output logic                            valid
);

    always_comb begin
        int idx;
        winner = '0;
        valid  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mt_arbiter.sv
// Shares one external MT19937 generator among NREQ requesters: reseeds it,
// waits for its table, then hands out one tempered number per grant.
module mt_arbiter
    import mt_pkg::*;
#(
    parameter int NREQ   = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [31:0]      seed_in,
    output logic             seed_busy,
    input  logic [NREQ-1:0]  req,
    output logic [NREQ-1:0]  gnt,
    output logic [31:0]      r_num,
    output logic [31:0]      served_cnt,
    output logic             gen_rst,
    output logic [31:0]      gen_seed,
    output logic             gen_trig,
    input  logic             gen_ready,
    input  logic [31:0]      gen_r_num
);

    localparam int          IW          = req_idx_width(NREQ);
    localparam logic [2:0]  SETTLE_LAST = 3'(SETTLE - 1);

    arb_state_e       state_q, state_d;
    logic [31:0]      seed_q, seed_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [31:0]      r_num_q, r_num_d;
    logic [31:0]      served_q, served_d;

    logic [NREQ-1:0]  win_oh;
    logic             win_valid;
    logic [IW-1:0]    win_idx;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .req    (req),
        .ptr    (ptr_q),
        .winner (win_oh),
        .valid  (win_valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win_oh[i]) begin
                win_idx = IW'(i);
            end
        end
    end

    // A reseed request overrides everything, including a grant that would
    // otherwise be issued this cycle.
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = '0;
        r_num_d    = '0;
        served_d   = served_q;
        gen_trig   = 1'b0;
        gen_rst    = (state_q == ST_RESEED);
        gen_seed   = seed_q;
        seed_busy  = (state_q == ST_RESEED) || (state_q == ST_FILL);

        if (seed_load) begin
            seed_d   = seed_in;
            served_d = '0;
            state_d  = ST_RESEED;
        end else begin
            case (state_q)
                ST_RESEED: begin
                    state_d = ST_FILL;
                end
                ST_FILL: begin
                    if (gen_ready) begin
                        state_d = ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (gen_ready && win_valid) begin
                        gen_trig = 1'b1;
                        gnt_d    = win_oh;
                        r_num_d  = gen_r_num;
                        ptr_d    = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
                        served_d = served_q + 32'd1;
                        cnt_d    = '0;
                        state_d  = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        state_d = ST_ARB;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: begin
                    state_d = ST_RESEED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RESEED;
            seed_q   <= MT_DEFAULT_SEED;
            ptr_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            r_num_q  <= '0;
            served_q <= '0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            r_num_q  <= r_num_d;
            served_q <= served_d;
        end
    end

    assign gnt        = gnt_q;
    assign r_num      = r_num_q;
    assign served_cnt = served_q;

endmodule

// File: tb/tb_mt_arbiter.sv
// Randomized scoreboard bench for mt_arbiter with a golden MT19937 generator
// and an independent MT19937 reference stream for expected numbers.
module tb_mt_arbiter;
    import mt_pkg::*;

    localparam int NREQ       = 4;
    localparam int SETTLE     = 1;
    localparam int FILL_LAT   = 4;
    localparam int REFILL_LAT = 700;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             seed_load = 1'b0;
    logic [31:0]      seed_in = '0;
    logic             seed_busy;
    logic [NREQ-1:0]  req = '0;
    logic [NREQ-1:0]  gnt;
    logic [31:0]      r_num;
    logic [31:0]      served_cnt;
    logic             gen_rst;
    logic [31:0]      gen_seed;
    logic             gen_trig;
    logic             gen_ready = 1'b0;
    logic [31:0]      gen_r_num = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    mt_arbiter #(
        .NREQ   (NREQ),
        .SETTLE (SETTLE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .seed_busy  (seed_busy),
        .req        (req),
        .gnt        (gnt),
        .r_num      (r_num),
        .served_cnt (served_cnt),
        .gen_rst    (gen_rst),
        .gen_seed   (gen_seed),
        .gen_trig   (gen_trig),
        .gen_ready  (gen_ready),
        .gen_r_num  (gen_r_num)
    );

    // Row 0 is the generator's state, row 1 the bench's reference stream.
    logic [31:0] mt_tab [2][MT_N];

    function automatic logic [31:0] temper(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y >> 11);
        y = y ^ ((y << 7) & 32'h9D2C5680);
        y = y ^ ((y << 15) & 32'hEFC60000);
        y = y ^ (y >> 18);
        return y;
    endfunction

    task automatic mt_seed(input int t, input logic [31:0] s);
        mt_tab[t][0] = s;
        for (int i = 1; i < MT_N; i++) begin
            mt_tab[t][i] = 32'd1812433253 * (mt_tab[t][i-1] ^ (mt_tab[t][i-1] >> 30)) + 32'(i);
        end
    endtask

    task automatic mt_twist(input int t);
        logic [31:0] y;
        for (int i = 0; i < MT_N; i++) begin
            y = (mt_tab[t][i] & 32'h80000000) | (mt_tab[t][(i + 1) % MT_N] & 32'h7FFFFFFF);
            mt_tab[t][i] = mt_tab[t][(i + 397) % MT_N] ^ (y >> 1) ^ (y[0] ? 32'h9908B0DF : 32'h0);
        end
    endtask

    int r_idx = MT_N;

    task automatic ref_next(output logic [31:0] v);
        if (r_idx == MT_N) begin
            mt_twist(1);
            r_idx = 0;
        end
        v = temper(mt_tab[1][r_idx]);
        r_idx++;
    endtask

    // Golden generator: table fill after seeding, and a long refill after
    // every 624 draws during which gen_ready is low.
    int g_idx  = 0;
    int g_wait = 0;
    initial forever begin
        @(posedge clk);
        if (gen_rst) begin
            mt_seed(0, gen_seed);
            g_wait = FILL_LAT;
            gen_ready <= 1'b0;
        end else if (g_wait > 0) begin
            g_wait--;
            if (g_wait == 0) begin
                mt_twist(0);
                g_idx = 0;
                gen_r_num <= temper(mt_tab[0][0]);
                gen_ready <= 1'b1;
            end
        end else if (gen_trig && gen_ready) begin
            g_idx++;
            if (g_idx == MT_N) begin
                gen_ready <= 1'b0;
                g_wait = REFILL_LAT;
            end else begin
                gen_r_num <= temper(mt_tab[0][g_idx]);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference model of the arbiter's observable behaviour.
    typedef enum {M_SEEDING, M_FILLING, M_READY, M_COOLING} m_phase_e;
    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [31:0]     num;
    } exp_t;

    exp_t        sb[$];
    m_phase_e    m_phase = M_SEEDING;
    int          m_ptr = 0;
    int          m_cool = 0;
    logic [31:0] m_seed = MT_DEFAULT_SEED;
    logic [31:0] m_served = '0;

    initial forever begin
        int w;
        logic [31:0] v;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_phase  = M_SEEDING;
            m_seed   = MT_DEFAULT_SEED;
            m_ptr    = 0;
            m_cool   = 0;
            m_served = '0;
            sb.delete();
        end else if (seed_load) begin
            m_seed   = seed_in;
            m_served = '0;
            m_phase  = M_SEEDING;
        end else begin
            case (m_phase)
                M_SEEDING: begin
                    mt_seed(1, m_seed);
                    r_idx   = MT_N;
                    m_phase = M_FILLING;
                end
                M_FILLING: if (gen_ready) m_phase = M_READY;
                M_READY: begin
                    if (gen_ready && req != '0) begin
                        w = -1;
                        for (int k = 0; k < NREQ; k++) begin
                            if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                        end
                        ref_next(v);
                        sb.push_back('{gnt: NREQ'(1) << w, num: v});
                        m_served = m_served + 32'd1;
                        m_ptr    = (w + 1) % NREQ;
                        m_cool   = SETTLE;
                        m_phase  = M_COOLING;
                    end
                end
                M_COOLING: begin
                    m_cool--;
                    if (m_cool == 0) m_phase = M_READY;
                end
                default: m_phase = M_SEEDING;
            endcase
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every cycle against the model and pops the scoreboard.
    logic prev_trig = 1'b0;
    logic prev_win  = 1'b0;
    int   win_cycles = 0;
    int   win_bad    = 0;

    initial forever begin
        logic exp_trig;
        logic win;
        exp_t e;
        @(negedge clk);
        #1;
        if (rst) begin
            prev_trig = 1'b0;
            prev_win  = 1'b0;
        end else begin
            exp_trig = (m_phase == M_READY) && gen_ready && (req != '0) && !seed_load;
            checkOutput("gen_trig", 32'(gen_trig), 32'(exp_trig));
            checkOutput("gen_rst", 32'(gen_rst), 32'(m_phase == M_SEEDING));
            checkOutput("seed_busy", 32'(seed_busy),
                        32'((m_phase == M_SEEDING) || (m_phase == M_FILLING)));
            if (m_phase == M_SEEDING) checkOutput("gen_seed", gen_seed, m_seed);
            checkOutput("served_cnt", served_cnt, m_served);
            checkOutput("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
            if (gen_trig) checkOutput("trig_needs_ready", 32'(gen_ready), 32'd1);
            checkOutput("gnt_after_trig", 32'(gnt != '0), 32'(prev_trig));
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("gnt", 32'(gnt), 32'(e.gnt));
                checkOutput("r_num", r_num, e.num);
            end else begin
                checkOutput("idle_gnt", 32'(gnt), 32'd0);
                checkOutput("idle_r_num", r_num, 32'd0);
            end
            win = !gen_ready && !seed_busy;
            if (win) begin
                win_cycles++;
                if (gen_trig) win_bad++;
            end
            if (win && prev_win && gnt != '0) win_bad++;
            prev_trig = gen_trig;
            prev_win  = win;
        end
    end

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic ld, input logic [31:0] s);
        @(negedge clk);
        req       = r;
        seed_load = ld;
        seed_in   = s;
    endtask

    task automatic waitGrant(input int budget, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (gnt != '0) ok = 1'b1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_gen_rst"}, 32'(gen_rst), 32'd1);
        checkOutput({tag, "_gen_trig"}, 32'(gen_trig), 32'd0);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_r_num"}, r_num, 32'd0);
        checkOutput({tag, "_served"}, served_cnt, 32'd0);
        checkOutput({tag, "_seed_busy"}, 32'(seed_busy), 32'd1);
        checkOutput({tag, "_gen_seed"}, gen_seed, 32'd5489);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        seed_load = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic ok;
        int   t_prev;

        repeat (3) @(negedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst = 1'b0;

        // Single requester after reset gets the first MT19937(5489) output.
        applyStimulus(4'b0001, 1'b0, 32'd0);
        waitGrant(50, ok);
        checkOutput("first_grant_seen", 32'(ok), 32'd1);
        checkOutput("first_gnt", 32'(gnt), 32'd1);
        checkOutput("first_r_num", r_num, 32'hD091BB5C);

        // All requesting: strict rotation, one grant every SETTLE+1 cycles.
        doReset();
        applyStimulus(4'b1111, 1'b0, 32'd0);
        t_prev = 0;
        for (int g = 0; g < 12; g++) begin
            waitGrant(20, ok);
            checkOutput("rot_seen", 32'(ok), 32'd1);
            checkOutput("rot_order", 32'(gnt), 32'(4'b0001 << (g % 4)));
            if (g > 0) checkOutput("rot_interval", 32'(cyc - t_prev), 32'(SETTLE + 1));
            t_prev = cyc;
        end
        checkOutput("rot_served", served_cnt, 32'd12);

        // Reseed lands on a cycle that would otherwise grant.
        applyStimulus(4'b1111, 1'b1, 32'd1);
        #1;
        checkOutput("ld_no_trig", 32'(gen_trig), 32'd0);
        applyStimulus(4'b1111, 1'b0, 32'd0);
        #1;
        checkOutput("ld_no_gnt", 32'(gnt), 32'd0);
        checkOutput("ld_gen_rst", 32'(gen_rst), 32'd1);
        checkOutput("ld_gen_seed", gen_seed, 32'd1);
        checkOutput("ld_served", served_cnt, 32'd0);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(4'b1111, 1'b0, 32'd0);
            #1;
            if (gen_ready) break;
            checkOutput("ld_busy_until_ready", 32'(seed_busy), 32'd1);
        end

        // Random requests with occasional reseeds.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 99) == 0), $urandom);
        end

        // Exhaust the table: 624 draws, then a 700-cycle refill with no grants.
        applyStimulus(4'b1111, 1'b1, 32'd5489);
        win_cycles = 0;
        win_bad    = 0;
        for (int i = 0; i < 2200; i++) begin
            applyStimulus(NREQ'($urandom_range(1, 15)), 1'b0, 32'd0);
        end
        checkOutput("refill_window_len", 32'(win_cycles), 32'(REFILL_LAT));
        checkOutput("refill_window_grants", 32'(win_bad), 32'd0);

        // Asynchronous reset while a grant pulse is showing.
        applyStimulus(4'b1111, 1'b0, 32'd0);
        waitGrant(20, ok);
        checkOutput("pre_rst_gnt_seen", 32'(ok), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        checkResetValues("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        req = 4'b0001;
        waitGrant(50, ok);
        checkOutput("replay_seen", 32'(ok), 32'd1);
        checkOutput("replay_gnt", 32'(gnt), 32'd1);
        checkOutput("replay_r_num", r_num, 32'hD091BB5C);

        for (int i = 0; i < 300; i++) begin
            applyStimulus(NREQ'($urandom_range(0, 15)), ($urandom_range(0, 149) == 0), $urandom);
        end
        applyStimulus('0, 1'b0, 32'd0);
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
